// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/WB controller for the small MIPS-style core.
// Ports:
//   clk, reset                 clock, async active-high reset
//   imem_req/addr/ack/data     instruction fetch handshake
//   rf_ra/rb/da/db             register-file read ports
//   rf_we/wa/wd                register-file write port
//   alu_a/b/op, alu_res        external ALU
//   resume                     leave HALT
//   pc, halted, illegal        status
//   retire                     one pulse per completed instruction
module multicycle_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int REG_AW  = 4,
    localparam int INSTR_W = 4 + 3 * REG_AW
) (
    input  logic               clk,
    input  logic               reset,

    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,

    output logic [REG_AW-1:0]  rf_ra,
    output logic [REG_AW-1:0]  rf_rb,
    input  logic [DATA_W-1:0]  rf_da,
    input  logic [DATA_W-1:0]  rf_db,
    output logic               rf_we,
    output logic [REG_AW-1:0]  rf_wa,
    output logic [DATA_W-1:0]  rf_wd,

    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [3:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_res,

    input  logic               resume,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               illegal,
    output logic               retire
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_CMPJ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      r_npc;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_illegal;
    logic                 r_req;
    logic                 r_halted;
    logic                 r_retire;
    logic [REG_AW-1:0]    r_rf_ra;
    logic [REG_AW-1:0]    r_rf_rb;
    logic                 r_rf_we;
    logic [REG_AW-1:0]    r_rf_wa;
    logic [DATA_W-1:0]    r_rf_wd;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic [3:0]           r_alu_op;

    logic [3:0]           w_op;
    logic [REG_AW-1:0]    w_rd;
    logic [2*REG_AW-1:0]  w_imm;
    logic [DATA_W-1:0]    w_imm_d;
    logic [PC_W-1:0]      w_imm_pc;
    logic [PC_W-1:0]      w_off;
    logic [PC_W-1:0]      w_pc_inc;
    logic [PC_W-1:0]      w_npc;
    logic                 w_is_ldi;
    logic                 w_is_alu;
    logic                 w_is_cmpj;
    logic                 w_is_jmp;
    logic                 w_is_halt;
    logic                 w_legal;
    logic                 w_writes;

    // Instruction fields; {ra,rb} doubles as the LDI/JMP immediate.
    assign w_op     = r_ir[INSTR_W-1 -: 4];
    assign w_rd     = r_ir[REG_AW-1:0];
    assign w_imm    = r_ir[3*REG_AW-1:REG_AW];
    assign w_imm_d  = DATA_W'(w_imm);
    assign w_imm_pc = PC_W'(w_imm);
    assign w_off    = PC_W'($signed(w_rd));
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_writes = w_is_ldi | w_is_alu;

    always_comb begin
        w_is_ldi  = 1'b0;
        w_is_alu  = 1'b0;
        w_is_cmpj = 1'b0;
        w_is_jmp  = 1'b0;
        w_is_halt = 1'b0;
        w_legal   = 1'b1;
        case (w_op)
            OP_NOP:  ;
            OP_LDI:  w_is_ldi = 1'b1;
            OP_ADD,
            OP_SUB,
            OP_AND,
            OP_OR,
            OP_XOR:  w_is_alu = 1'b1;
            OP_CMPJ: w_is_cmpj = 1'b1;
            OP_JMP:  w_is_jmp = 1'b1;
            OP_HALT: w_is_halt = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // HALT and trapping opcodes leave pc where it is.
    always_comb begin
        w_npc = w_pc_inc;
        if (w_is_cmpj) begin
            w_npc = alu_res[0] ? (r_pc + w_off) : w_pc_inc;
        end else if (w_is_jmp) begin
            w_npc = w_imm_pc;
        end else if (w_is_halt || !w_legal) begin
            w_npc = r_pc;
        end
    end

    // Every output is a register that is loaded on entry to the
    // state that owns it and cleared on the way out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IF;
            r_pc      <= '0;
            r_npc     <= '0;
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_req     <= 1'b1;
            r_halted  <= 1'b0;
            r_retire  <= 1'b0;
            r_rf_ra   <= '0;
            r_rf_rb   <= '0;
            r_rf_we   <= 1'b0;
            r_rf_wa   <= '0;
            r_rf_wd   <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
        end else begin
            unique case (r_state)
                S_IF: begin
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_req   <= 1'b0;
                        r_rf_ra <= imem_data[3*REG_AW-1 -: REG_AW];
                        r_rf_rb <= imem_data[2*REG_AW-1 -: REG_AW];
                        r_state <= S_ID;
                    end
                end
                S_ID: begin
                    // The ALU operand outputs are the operand registers.
                    r_rf_ra  <= '0;
                    r_rf_rb  <= '0;
                    r_alu_a  <= rf_da;
                    r_alu_b  <= rf_db;
                    r_alu_op <= w_op;
                    r_state  <= S_EX;
                end
                S_EX: begin
                    r_alu_a  <= '0;
                    r_alu_b  <= '0;
                    r_alu_op <= '0;
                    r_npc    <= w_npc;
                    r_retire <= 1'b1;
                    r_rf_we  <= w_writes;
                    r_rf_wa  <= w_writes ? w_rd : '0;
                    if (w_is_ldi) begin
                        r_rf_wd <= w_imm_d;
                    end else if (w_is_alu) begin
                        r_rf_wd <= alu_res;
                    end else begin
                        r_rf_wd <= '0;
                    end
                    r_state  <= S_WB;
                end
                S_WB: begin
                    r_retire <= 1'b0;
                    r_rf_we  <= 1'b0;
                    r_rf_wa  <= '0;
                    r_rf_wd  <= '0;
                    r_pc     <= r_npc;
                    if (w_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (!w_legal) begin
                        r_illegal <= 1'b1;
                        r_halted  <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_req   <= 1'b1;
                        r_state <= S_IF;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        r_pc     <= w_pc_inc;
                        r_halted <= 1'b0;
                        r_req    <= 1'b1;
                        r_state  <= S_IF;
                    end
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_IF;
                end
            endcase
        end
    end

    // The request is gated by reset so it drops without waiting
    // for a clock edge.
    assign imem_req  = r_req & ~reset;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign rf_ra     = r_rf_ra;
    assign rf_rb     = r_rf_rb;
    assign rf_we     = r_rf_we;
    assign rf_wa     = r_rf_wa;
    assign rf_wd     = r_rf_wd;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign halted    = r_halted;
    assign illegal   = r_illegal;
    assign retire    = r_retire;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed programs plus a random
// program checked against an instruction-level model.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [3:0]  rf_ra, rf_rb, rf_wa;
    logic [7:0]  rf_da, rf_db, rf_wd;
    logic        rf_we;
    logic [7:0]  alu_a, alu_b, alu_res;
    logic [3:0]  alu_op;
    logic        resume;
    logic [7:0]  pc;
    logic        halted, illegal, retire;

    multicycle_ctrl #(
        .DATA_W (8),
        .PC_W   (8),
        .REG_AW (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_da     (rf_da),
        .rf_db     (rf_db),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .resume    (resume),
        .pc        (pc),
        .halted    (halted),
        .illegal   (illegal),
        .retire    (retire)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] imem [256];
    logic [7:0]  R  [16] = '{default: 8'h00};
    logic [7:0]  MR [16];
    logic [7:0]  mpc;
    int          cmp_force;
    int          lat_fix;
    int          last_n;
    int          cur_lat;
    int          fcnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Environment: register file, ALU and instruction memory.
    assign rf_da = R[rf_ra];
    assign rf_db = R[rf_rb];

    always @(posedge clk) begin
        if (rf_we) R[rf_wa] <= rf_wd;
    end

    always_comb begin
        case (alu_op)
            4'h2: alu_res = alu_a + alu_b;
            4'h3: alu_res = alu_a - alu_b;
            4'h4: alu_res = alu_a & alu_b;
            4'h5: alu_res = alu_a | alu_b;
            4'h6: alu_res = alu_a ^ alu_b;
            4'h8: alu_res = (cmp_force >= 0) ? 8'(cmp_force)
                                            : {7'd0, alu_a == alu_b};
            default: alu_res = 8'h00;
        endcase
    end

    initial begin
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        fcnt      = 0;
        last_n    = 0;
        cur_lat   = 1;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                if (fcnt == 0)
                    cur_lat = (lat_fix > 0) ? lat_fix
                                            : int'($urandom_range(1, 4));
                fcnt++;
                if (fcnt >= cur_lat) begin
                    imem_ack  = 1'b1;
                    imem_data = imem[imem_addr];
                    last_n    = fcnt;
                    fcnt      = 0;
                end else begin
                    imem_ack  = 1'b0;
                    imem_data = 16'($urandom);
                end
            end else begin
                imem_ack = 1'b0;
                fcnt     = 0;
            end
        end
    end

    function automatic bit legal_op(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                          4'h6, 4'h8, 4'hE, 4'hF};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_retire", retire, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_aluop", alu_op, 0);
        chk("rst_ra", rf_ra, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        mpc = 8'h00;
        #1 chk("rst_req_rel", imem_req, 1);
    endtask

    // Runs the instruction at the model pc and checks the WB outputs,
    // latency and resulting pc. HALT is held 'hold' cycles then resumed.
    task automatic exec_one(input int hold, output int cyc);
        logic [15:0] ins;
        logic [3:0]  op, ra, rb, rd;
        logic        wr;
        logic [7:0]  wd, npc;
        int          off;
        bit          tk, done;
        ins = imem[mpc];
        op  = ins[15:12];
        ra  = ins[11:8];
        rb  = ins[7:4];
        rd  = ins[3:0];
        wr  = 1'b0;
        wd  = 8'h00;
        npc = 8'(int'(mpc) + 1);
        case (op)
            4'h1: begin wr = 1; wd = {ra, rb}; end
            4'h2: begin wr = 1; wd = 8'(int'(MR[ra]) + int'(MR[rb])); end
            4'h3: begin wr = 1; wd = 8'(int'(MR[ra]) - int'(MR[rb])); end
            4'h4: begin wr = 1; wd = MR[ra] & MR[rb]; end
            4'h5: begin wr = 1; wd = MR[ra] | MR[rb]; end
            4'h6: begin wr = 1; wd = MR[ra] ^ MR[rb]; end
            4'h8: begin
                tk  = (cmp_force >= 0) ? (cmp_force != 0)
                                       : (MR[ra] == MR[rb]);
                off = rd[3] ? int'(rd) - 16 : int'(rd);
                if (tk) npc = 8'(int'(mpc) + off);
            end
            4'hE: npc = {ra, rb};
            4'h0: ;
            default: npc = mpc;
        endcase
        cyc  = 0;
        done = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (imem_req) chk("imem_addr", imem_addr, mpc);
            if (retire) done = 1;
            else chk("we_outside_wb", rf_we, 0);
        end
        if (!done) begin
            chk("retire_timeout", 0, 1);
            return;
        end
        chk("latency", cyc, last_n + 3);
        chk("rf_we", rf_we, wr);
        if (wr) begin
            chk("rf_wa", rf_wa, rd);
            chk("rf_wd", rf_wd, wd);
        end
        @(posedge clk);
        #1;
        if (wr) MR[rd] = wd;
        chk("pc_next", pc, npc);
        mpc = npc;
        if (op == 4'hF) begin
            chk("halt_flag", halted, 1);
            repeat (hold) begin
                @(negedge clk);
                chk("halt_held", halted, 1);
                chk("halt_pc", pc, mpc);
                chk("halt_noreq", imem_req, 0);
            end
            resume = 1'b1;
            @(posedge clk);
            #1 resume = 1'b0;
            mpc = 8'(int'(mpc) + 1);
            chk("resume_pc", pc, mpc);
            chk("resume_req", imem_req, 1);
        end else if (!legal_op(op)) begin
            chk("trap_halted", halted, 1);
            chk("trap_illegal", illegal, 1);
        end else begin
            chk("run_halted", halted, 0);
        end
    endtask

    logic [3:0] optab [12] = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4,
                               4'h5, 4'h6, 4'h8, 4'h8, 4'hE, 4'hF};

    initial begin
        int c;
        bit seen;
        reset     = 1'b1;
        resume    = 1'b0;
        cmp_force = -1;
        lat_fix   = 1;
        mpc       = 8'h00;
        for (int i = 0; i < 16; i++) MR[i] = 8'h00;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;

        imem[8'h00] = 16'h15A1;
        imem[8'h01] = 16'hEC30;
        imem[8'hC3] = 16'hE200;
        imem[8'h20] = 16'hF000;
        imem[8'h21] = 16'h9000;
        do_reset();

        lat_fix = 1;
        exec_one(0, c);
        chk("ldi_cycles", c, 4);
        chk("ldi_pc", pc, 8'h01);
        chk("ldi_r1", R[1], 8'h5A);

        lat_fix = 3;
        exec_one(0, c);
        chk("jmp_cycles", c, 6);
        chk("jmp_pc", pc, 8'hC3);

        lat_fix = 2;
        exec_one(0, c);
        exec_one(10, c);
        chk("halt_resume_pc", pc, 8'h21);

        exec_one(0, c);
        resume = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("trap_stays", halted, 1);
            chk("trap_pc", pc, 8'h21);
            chk("trap_noreq", imem_req, 0);
        end
        resume = 1'b0;
        do_reset();
        chk("trap_cleared", illegal, 0);

        lat_fix = 1;
        exec_one(0, c);
        lat_fix = 5;
        repeat (2) @(negedge clk);
        chk("pend_req", imem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("pend_rst_req", imem_req, 0);
        chk("pend_rst_pc", pc, 0);
        chk("pend_rst_retire", retire, 0);
        chk("pend_rst_we", rf_we, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        mpc = 8'h00;

        imem[8'h00] = 16'h1AA5;
        lat_fix = 1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (retire) seen = 1;
        end
        chk("wb_reached", seen, 1);
        #1 reset = 1'b1;
        #1;
        chk("wb_rst_we", rf_we, 0);
        chk("wb_rst_retire", retire, 0);
        chk("wb_rst_pc", pc, 0);
        @(posedge clk);
        #1;
        chk("wb_rst_nowrite", R[5], MR[5]);
        reset = 1'b0;
        mpc = 8'h00;

        imem[8'h00] = 16'h1072;
        imem[8'h01] = 16'h1073;
        imem[8'h02] = 16'hE100;
        imem[8'h10] = 16'h823E;
        do_reset();
        cmp_force = 1;
        repeat (4) exec_one(0, c);
        chk("cmpj_taken", pc, 8'h0E);
        do_reset();
        cmp_force = 0;
        repeat (4) exec_one(0, c);
        chk("cmpj_not_taken", pc, 8'h11);
        imem[8'h00] = 16'h823F;
        do_reset();
        cmp_force = 1;
        exec_one(0, c);
        chk("cmpj_wrap", pc, 8'hFF);
        cmp_force = -1;

        for (int i = 0; i < 256; i++)
            imem[i] = {optab[$urandom_range(0, 11)], 12'($urandom)};
        do_reset();
        lat_fix = 0;
        for (int n = 0; n < 250; n++)
            exec_one(int'($urandom_range(1, 3)), c);
        for (int i = 0; i < 16; i++) chk("rf_final", R[i], MR[i]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
